// File: rtl/student_pkg.sv
// Shared constants and types for the 8-way collector path: channel count, select width, output state.
package student_pkg;
   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] g);
      return g + SEL_W'(1);
   endfunction
endpackage

// File: rtl/student_mux8way.sv
// Combinational 8:1 word selector; AND-OR structure so each channel lane is a gated copy.
module student_mux8way
   import student_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [WIDTH-1:0]        out_data
);

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         out_data = out_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(i)}});
      end
   end

endmodule

// File: rtl/student_mux8way_collector.sv
// Merges eight valid/ready producers into one registered stream with round-robin arbitration.
module student_mux8way_collector
   import student_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SEL_W-1:0]   sel_q, sel_d;

   logic               grant_vld;
   logic [SEL_W-1:0]   grant_idx;
   logic [SEL_W-1:0]   scan_idx;
   logic               load_en;
   logic               xfer;
   logic [WIDTH-1:0]   mux_word;

   // Scan from the farthest offset back toward ptr so the nearest valid channel wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = ptr_q;
      scan_idx  = ptr_q;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         scan_idx = ptr_q + SEL_W'(k);
         if (in_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   student_mux8way #(.WIDTH(WIDTH)) u_mux (
      .sel      (grant_idx),
      .in_data  (in_data),
      .out_data (mux_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (xfer) begin
         state_d = ST_FULL;
         ptr_d   = rr_next(grant_idx);
         data_d  = mux_word;
         sel_d   = grant_idx;
      end else if (state_q == ST_FULL && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // rst_n gates in_ready so nothing is accepted while reset is held.
   always_comb begin
      load_en  = (state_q == ST_EMPTY) || out_ready;
      xfer     = rst_n && load_en && grant_vld;
      in_ready = '0;
      if (xfer) in_ready[grant_idx] = 1'b1;
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_student_mux8way_collector.sv
// Directed table-driven bench for the 8-way round-robin collector.
module tb_student_mux8way_collector;

   localparam int W = 16;

   logic          clk;
   logic          rst_n;
   logic [7:0]    in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]    in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [2:0]    out_sel;
   logic          out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] vld;
      logic       ordy;
      logic [7:0] exp_rdy;
      logic       exp_ov;
      logic [2:0] exp_sel;
      logic [W-1:0] exp_data;
   } vec_t;

   vec_t tbl[$];

   student_mux8way_collector #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] word(input int ch);
      if (ch == 5) return 16'hA5A5;
      return 16'(16'h1111 * (ch + 1));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Called one time unit after a rising edge: drive, check in_ready, clock, check outputs.
   task automatic apply(input vec_t v);
      in_valid  = v.vld;
      out_ready = v.ordy;
      #2;
      chk({v.name, ".in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
      @(posedge clk);
      #1;
      chk({v.name, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
      chk({v.name, ".out_sel"},   32'(out_sel),   32'(v.exp_sel));
      chk({v.name, ".out_data"},  32'(out_data),  32'(v.exp_data));
   endtask

   initial begin
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = word(i);

      // All channels valid from ch0 round to ch1 again: no gaps.
      for (int i = 0; i < 10; i++)
         tbl.push_back('{"allvld", 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), word(i % 8)});
      tbl.push_back('{"single5",  8'h20, 1'b1, 8'h20, 1'b1, 3'd5, word(5)});
      tbl.push_back('{"ptr6",     8'h41, 1'b1, 8'h40, 1'b1, 3'd6, word(6)});
      tbl.push_back('{"wrap7",    8'h82, 1'b1, 8'h80, 1'b1, 3'd7, word(7)});
      tbl.push_back('{"wrap1",    8'h82, 1'b1, 8'h02, 1'b1, 3'd1, word(1)});
      tbl.push_back('{"ptr2",     8'h09, 1'b1, 8'h08, 1'b1, 3'd3, word(3)});
      tbl.push_back('{"drain",    8'h00, 1'b1, 8'h00, 1'b0, 3'd3, word(3)});
      tbl.push_back('{"bp_load",  8'h04, 1'b0, 8'h04, 1'b1, 3'd2, word(2)});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{"bp_hold", 8'h14, 1'b0, 8'h00, 1'b1, 3'd2, word(2)});
      tbl.push_back('{"bp_release", 8'h14, 1'b1, 8'h10, 1'b1, 3'd4, word(4)});

      rst_n     = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready",  32'(in_ready),  32'h00);
      chk("rst.out_valid", 32'(out_valid), 32'h0);
      chk("rst.out_sel",   32'(out_sel),   32'h0);
      chk("rst.out_data",  32'(out_data),  32'h0);
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // Asynchronous reset while FULL with ch4's word, then ch0 beats ch3.
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 32'(out_valid), 32'h0);
      chk("midrst.in_ready",  32'(in_ready),  32'h00);
      chk("midrst.out_sel",   32'(out_sel),   32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply('{"postrst0", 8'h09, 1'b1, 8'h01, 1'b1, 3'd0, word(0)});
      apply('{"postrst3", 8'h09, 1'b1, 8'h08, 1'b1, 3'd3, word(3)});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
